// File: rtl/datapath_seq.sv
//------------------------------------------------------------------------------
// datapath_seq
//
// Register-file datapath with a built-in command sequencer. One handshaken
// command runs read A, read B, execute and writeback on its own, so the
// command source never has to drive per-stage switch controls.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  high exactly while the sequencer is idle
//   cmd_op     0 MOVI, 1 MOV, 2 ADD, 3 CMP, 4 AND, 5 MVN, 6-7 reserved
//   cmd_rd     destination register
//   cmd_rn     first operand register (A)
//   cmd_rm     second operand register (B, passes through the shifter)
//   cmd_shift  0 none, 1 LSL1, 2 LSR1 (zero fill), 3 ASR1
//   cmd_imm    immediate for MOVI
//   busy       inverse of cmd_ready
//   done       one-cycle pulse when a command completes
//   result     C register
//   status     {V, N, Z}
//   dbg_addr   debug read address
//   dbg_data   combinational R[dbg_addr]
//------------------------------------------------------------------------------
module datapath_seq #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rn,
  input  logic [REG_AW-1:0] cmd_rm,
  input  logic [1:0]        cmd_shift,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [2:0]        status,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int NREGS = 2**REG_AW;

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_CMP  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_MVN  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADB,
    S_EXEC,
    S_WRITE
  } state_t;

  // Single-bit shifter applied to the B operand.
  function automatic logic signed [WIDTH-1:0] shift_b(
    input logic signed [WIDTH-1:0] b,
    input logic [1:0]              sh
  );
    case (sh)
      2'd1:    shift_b = b <<< 1;
      2'd2:    shift_b = b >> 1;   // logical: zero fill even on a signed operand
      2'd3:    shift_b = b >>> 1;
      default: shift_b = b;
    endcase
  endfunction

  // ALU result, wrapping modulo 2**WIDTH. MOV/MVN ignore A entirely.
  function automatic logic signed [WIDTH-1:0] alu_res(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] bs
  );
    case (op)
      OP_ADD:  alu_res = a + bs;
      OP_CMP:  alu_res = a - bs;
      OP_AND:  alu_res = a & bs;
      OP_MOV:  alu_res = bs;
      OP_MVN:  alu_res = ~bs;
      default: alu_res = '0;
    endcase
  endfunction

  // Two's-complement overflow; only arithmetic ops can set V.
  function automatic logic alu_ovf(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] bs,
    input logic signed [WIDTH-1:0] y
  );
    case (op)
      OP_ADD:  alu_ovf = (a[WIDTH-1] == bs[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      OP_CMP:  alu_ovf = (a[WIDTH-1] != bs[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  endfunction

  state_t state, state_nx;

  // Captured command fields; the source may change its inputs after accept.
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rn_q;
  logic [REG_AW-1:0] rm_q;
  logic [1:0]        sh_q;

  logic signed [WIDTH-1:0] rf [NREGS];
  logic signed [WIDTH-1:0] a_reg;
  logic signed [WIDTH-1:0] b_reg;
  logic signed [WIDTH-1:0] c_reg;
  logic [2:0]              status_reg;

  logic signed [WIDTH-1:0] bs;
  logic signed [WIDTH-1:0] alu_y;
  logic                    alu_v;

  logic accept;
  logic ld_a;
  logic ld_b;
  logic exec;
  logic wr_rf;
  logic fin;

  //----------------------------------------------------------------------------
  // Sequencer: state register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  //----------------------------------------------------------------------------
  // Sequencer: next state
  //----------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_MOVI:                state_nx = S_WRITE;
            OP_MOV, OP_MVN:         state_nx = S_LOADB;
            OP_ADD, OP_CMP, OP_AND: state_nx = S_LOADA;
            default:                state_nx = S_IDLE;  // reserved: done pulse only
          endcase
        end
      end
      S_LOADA: state_nx = S_LOADB;
      S_LOADB: state_nx = S_EXEC;
      S_EXEC:  state_nx = (op_q == OP_CMP) ? S_IDLE : S_WRITE;
      S_WRITE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  //----------------------------------------------------------------------------
  // Sequencer: outputs and datapath strobes
  //----------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state == S_IDLE);
    accept    = cmd_valid && cmd_ready;
    ld_a      = (state == S_LOADA);
    ld_b      = (state == S_LOADB);
    exec      = (state == S_EXEC);
    wr_rf     = (state == S_WRITE);
    // Last edge of a command: writeback, CMP's execute, or a reserved accept.
    fin       = wr_rf || (exec && (op_q == OP_CMP)) || (accept && (cmd_op > OP_MVN));
  end

  assign busy = ~cmd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else begin
      done <= fin;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= cmd_op;
      rd_q <= cmd_rd;
      rn_q <= cmd_rn;
      rm_q <= cmd_rm;
      sh_q <= cmd_shift;
    end
  end

  //----------------------------------------------------------------------------
  // Execute stage: shifter and ALU on the A/B registers
  //----------------------------------------------------------------------------
  always_comb begin
    bs    = shift_b(b_reg, sh_q);
    alu_y = alu_res(op_q, a_reg, bs);
    alu_v = alu_ovf(op_q, a_reg, bs, alu_y);
  end

  //----------------------------------------------------------------------------
  // Operand, result and status registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      status_reg <= '0;
    end else begin
      if (ld_a) begin
        a_reg <= rf[rn_q];
      end
      if (ld_b) begin
        b_reg <= rf[rm_q];
      end
      // MOVI bypasses the ALU: the immediate lands in C at the accept edge.
      if (accept && (cmd_op == OP_MOVI)) begin
        c_reg <= cmd_imm;
      end else if (exec && (op_q != OP_CMP)) begin
        c_reg <= alu_y;
      end
      if (exec) begin
        status_reg <= {alu_v, alu_y[WIDTH-1], (alu_y == '0)};
      end
    end
  end

  //----------------------------------------------------------------------------
  // Writeback stage: register file
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_rf) begin
      rf[rd_q] <= c_reg;
    end
  end

  assign result   = c_reg;
  assign status   = status_reg;
  assign dbg_data = rf[dbg_addr];

endmodule
